// File: rtl/job_seq_unpack_pkg.sv
// Shared field layout of the packed 64-bit sequence word,
// error encodings and skid-buffer state encoding.
package job_seq_unpack_pkg;

    localparam int SEQ_VALID_BIT     = 0;
    localparam int SEQ_DELIM_BIT     = 1;
    localparam int SEQ_EOJ_BIT       = 2;
    localparam int SEQ_OVL_BIT       = 3;
    localparam int SEQ_RSVD_LSB      = 4;
    localparam int SEQ_RSVD_W        = 4;
    localparam int SEQ_OVL_LEN_LSB   = 8;
    localparam int SEQ_OVL_LEN_W     = 8;
    localparam int SEQ_LIT_LEN_LSB   = 16;
    localparam int SEQ_LIT_LEN_W     = 16;
    localparam int SEQ_OFFSET_LSB    = 32;
    localparam int SEQ_OFFSET_W      = 24;
    localparam int SEQ_MATCH_LEN_LSB = 56;
    localparam int SEQ_MATCH_LEN_W   = 8;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_INVALID  = 2'd1,
        ERR_RESERVED = 2'd2,
        ERR_DELIM    = 2'd3
    } err_code_t;

    typedef enum logic [1:0] {
        SB_EMPTY = 2'd0,
        SB_ONE   = 2'd1,
        SB_TWO   = 2'd2
    } sb_state_t;

endpackage

// File: rtl/job_seq_unpack_skid.sv
// Two-entry valid/ready skid buffer: registered output plus
// one skid slot, so in_ready never depends on out_ready.
module seq_skid_buf
    import job_seq_unpack_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    sb_state_t    state;
    sb_state_t    state_nxt;
    logic [W-1:0] skid;
    logic         push;
    logic         pop;
    logic         load_out;
    logic         load_skid;
    logic         use_skid;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // State register and registered in_ready (low only when both slots full)
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SB_EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != SB_TWO);
        end
    end

    // Next-state: occupancy follows push/pop
    always_comb begin
        state_nxt = state;
        unique case (state)
            SB_EMPTY: if (push) state_nxt = SB_ONE;
            SB_ONE: begin
                if (push && !pop)      state_nxt = SB_TWO;
                else if (!push && pop) state_nxt = SB_EMPTY;
            end
            SB_TWO:   if (pop) state_nxt = SB_ONE;
            default:  state_nxt = SB_EMPTY;
        endcase
    end

    // Output decode: which data register loads from where
    always_comb begin
        out_valid = (state != SB_EMPTY);
        load_out  = 1'b0;
        load_skid = 1'b0;
        use_skid  = 1'b0;
        unique case (state)
            SB_EMPTY: load_out = push;
            SB_ONE: begin
                load_skid = push && !pop;
                load_out  = push && pop;
            end
            SB_TWO: begin
                load_out = pop;
                use_skid = pop;
            end
            default: ;
        endcase
    end

    // Data registers; output only changes on load, so it holds under stall
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            skid     <= '0;
        end else begin
            if (load_out)  out_data <= use_skid ? skid : in_data;
            if (load_skid) skid     <= in_data;
        end
    end

endmodule

// File: rtl/job_seq_unpack.sv
// Sequence word unpacker: field decode, job cursor tracking,
// sticky error capture, skid-buffered output.
module job_seq_unpack
    import job_seq_unpack_pkg::*;
#(
    parameter int POS_WIDTH = 24,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [63:0]          in_seq,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          out_lit_len,
    output logic [7:0]           out_match_len,
    output logic [23:0]          out_offset,
    output logic                 out_has_overlap,
    output logic [7:0]           out_overlap_len,
    output logic [POS_WIDTH-1:0] out_pos,
    output logic [CNT_WIDTH-1:0] out_seq_idx,
    output logic                 out_end_of_job,
    output logic                 out_delim,
    output logic                 err,
    output logic [1:0]           err_code
);

    localparam int PW = 59 + POS_WIDTH + CNT_WIDTH;

    logic [SEQ_LIT_LEN_W-1:0]   lit_len;
    logic [SEQ_MATCH_LEN_W-1:0] match_len;
    logic [SEQ_OFFSET_W-1:0]    offset;
    logic [SEQ_OVL_LEN_W-1:0]   ovl_len;
    logic [SEQ_RSVD_W-1:0]      rsvd;
    logic                       vbit;
    logic                       delim;
    logic                       eoj;
    logic                       ovl;

    logic                 accept;
    logic                 good;
    logic [1:0]           code;
    logic [POS_WIDTH-1:0] cur_pos;
    logic [CNT_WIDTH-1:0] cur_idx;
    logic [PW-1:0]        push_data;
    logic [PW-1:0]        buf_data;

    assign vbit      = in_seq[SEQ_VALID_BIT];
    assign delim     = in_seq[SEQ_DELIM_BIT];
    assign eoj       = in_seq[SEQ_EOJ_BIT];
    assign ovl       = in_seq[SEQ_OVL_BIT];
    assign rsvd      = in_seq[SEQ_RSVD_LSB +: SEQ_RSVD_W];
    assign ovl_len   = in_seq[SEQ_OVL_LEN_LSB +: SEQ_OVL_LEN_W];
    assign lit_len   = in_seq[SEQ_LIT_LEN_LSB +: SEQ_LIT_LEN_W];
    assign offset    = in_seq[SEQ_OFFSET_LSB +: SEQ_OFFSET_W];
    assign match_len = in_seq[SEQ_MATCH_LEN_LSB +: SEQ_MATCH_LEN_W];

    assign accept = in_valid && in_ready;
    assign good   = accept && vbit;

    // Classify the incoming word; lower code wins when several apply
    always_comb begin
        code = ERR_NONE;
        if (!vbit)
            code = ERR_INVALID;
        else if (rsvd != '0)
            code = ERR_RESERVED;
        else if (delim && !eoj)
            code = ERR_DELIM;
    end

    // A delim is only meaningful on a job's last word
    assign push_data = {lit_len, match_len, offset, ovl, ovl_len,
                        cur_pos, cur_idx, eoj, delim && eoj};

    // Job cursor: advance per good word, rewind after end_of_job
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_pos <= '0;
            cur_idx <= '0;
        end else if (good) begin
            if (eoj) begin
                cur_pos <= '0;
                cur_idx <= '0;
            end else begin
                cur_pos <= cur_pos + POS_WIDTH'(lit_len)
                                   + POS_WIDTH'(match_len);
                if (cur_idx != '1)
                    cur_idx <= cur_idx + 1'b1;
            end
        end
    end

    // Sticky error; code captured only on the first error
    always_ff @(posedge clk) begin
        if (rst) begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else if (accept && code != ERR_NONE && !err) begin
            err      <= 1'b1;
            err_code <= code;
        end
    end

    seq_skid_buf #(.W(PW)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid && vbit),
        .in_data  (push_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (buf_data)
    );

    assign {out_lit_len, out_match_len, out_offset, out_has_overlap,
            out_overlap_len, out_pos, out_seq_idx, out_end_of_job,
            out_delim} = buf_data;

endmodule

// File: tb/tb_job_seq_unpack.sv
// Scoreboard bench for job_seq_unpack: directed scenarios plus
// random traffic against a behavioural cursor/error model.
module tb_job_seq_unpack;

    typedef struct packed {
        logic [15:0] lit;
        logic [7:0]  mat;
        logic [23:0] off;
        logic        ovl;
        logic [7:0]  ovll;
        logic [23:0] pos;
        logic [15:0] idx;
        logic        eoj;
        logic        delim;
    } seq_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic [63:0] in_seq = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1;
    logic [15:0] out_lit_len;
    logic [7:0]  out_match_len;
    logic [23:0] out_offset;
    logic        out_has_overlap;
    logic [7:0]  out_overlap_len;
    logic [23:0] out_pos;
    logic [15:0] out_seq_idx;
    logic        out_end_of_job;
    logic        out_delim;
    logic        err;
    logic [1:0]  err_code;

    int   checks = 0;
    int   errors = 0;
    int   mode = 0;
    seq_t q[$];

    longint unsigned m_pos = 0;
    int unsigned     m_idx = 0;
    logic            m_err = 0;
    logic [1:0]      m_code = 0;

    job_seq_unpack dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_seq(in_seq),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_lit_len(out_lit_len), .out_match_len(out_match_len),
        .out_offset(out_offset), .out_has_overlap(out_has_overlap),
        .out_overlap_len(out_overlap_len), .out_pos(out_pos),
        .out_seq_idx(out_seq_idx), .out_end_of_job(out_end_of_job),
        .out_delim(out_delim), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input int lit, input int mat,
                                       input int off, input bit eoj,
                                       input bit delim, input int rsvd = 0,
                                       input bit vbit = 1);
        logic [63:0] w;
        w = '0;
        w[0] = vbit;
        w[1] = delim;
        w[2] = eoj;
        w[3] = off[0];
        w[7:4] = rsvd[3:0];
        w[15:8] = off[7:0] ^ 8'h5a;
        w[31:16] = lit[15:0];
        w[55:32] = off[23:0];
        w[63:56] = mat[7:0];
        return w;
    endfunction

    // Reference model applied to each accepted word
    task automatic model(input logic [63:0] w);
        seq_t e;
        int   c;
        bit   v, dl, ej;
        v  = w[0];
        dl = w[1];
        ej = w[2];
        if (!v) c = 1;
        else if (w[7:4] != 0) c = 2;
        else if (dl && !ej) c = 3;
        else c = 0;
        if (c != 0 && !m_err) begin
            m_err  = 1;
            m_code = c[1:0];
        end
        if (!v) return;
        e.lit   = w[31:16];
        e.mat   = w[63:56];
        e.off   = w[55:32];
        e.ovl   = w[3];
        e.ovll  = w[15:8];
        e.pos   = m_pos[23:0];
        e.idx   = m_idx[15:0];
        e.eoj   = ej;
        e.delim = dl && ej;
        q.push_back(e);
        if (ej) begin
            m_pos = 0;
            m_idx = 0;
        end else begin
            m_pos = (m_pos + e.lit + e.mat) % (64'd1 << 24);
            if (m_idx < 65535) m_idx++;
        end
    endtask

    task automatic send(input logic [63:0] w);
        bit acc;
        int n;
        in_valid = 1;
        in_seq   = w;
        n = 0;
        do begin
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout: got no accept expected accept");
            in_valid = 0;
        end else begin
            model(w);
        end
    endtask

    task automatic idle();
        in_valid = 0;
        in_seq   = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk);
        q.delete();
        m_pos  = 0;
        m_idx  = 0;
        m_err  = 0;
        m_code = 0;
        #1 rst = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("drain_empty", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Downstream ready pattern
    initial forever begin
        @(posedge clk);
        #1;
        if (mode == 0) out_ready = 1;
        else if (mode == 2) out_ready = 0;
        else out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: handshake, stability, error and payload checks
    seq_t held;
    bit   stall_prev = 0;
    always @(negedge clk) begin
        seq_t act;
        act = {out_lit_len, out_match_len, out_offset, out_has_overlap,
               out_overlap_len, out_pos, out_seq_idx, out_end_of_job,
               out_delim};
        if (rst) begin
            stall_prev = 0;
        end else begin
            chk("in_ready", in_ready, q.size() < 2);
            chk("out_valid", out_valid, q.size() > 0);
            chk("err", err, m_err);
            chk("err_code", err_code, m_code);
            if (stall_prev) chk("stable", act, held);
            stall_prev = out_valid && !out_ready;
            held = act;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_out: got pos %0h expected none",
                             out_pos);
                end else begin
                    chk("payload", act, q.pop_front());
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_err", {err, err_code}, 0);
        chk("rst_fields", {out_lit_len, out_match_len, out_offset,
            out_has_overlap, out_overlap_len, out_pos, out_seq_idx,
            out_end_of_job, out_delim}, 0);
        @(posedge clk);
        #1;

        // Single job, latency one cycle
        mode = 0;
        send(mk(5, 4, 100, 0, 0));
        chk("latency_valid", out_valid, 1);
        chk("latency_pos", out_pos, 0);
        send(mk(0, 10, 200, 0, 0));
        chk("second_pos", out_pos, 9);
        send(mk(3, 0, 300, 1, 0));
        chk("third_pos", out_pos, 19);
        chk("third_idx", out_seq_idx, 2);
        idle();
        drain();

        // Two jobs, delimited end on the second word
        send(mk(7, 3, 11, 0, 0));
        send(mk(2, 2, 12, 1, 1));
        send(mk(4, 4, 13, 0, 0));
        send(mk(1, 1, 14, 1, 0));
        idle();
        drain();

        // Backpressure under continuous input
        mode = 2;
        fork
            for (int i = 0; i < 6; i++) send(mk(i + 1, i, 40 + i, 0, 0));
            begin
                repeat (5) @(posedge clk);
                mode = 0;
            end
        join
        idle();
        drain();

        // Dropped word between good words
        send(mk(6, 6, 21, 0, 0));
        send(mk(9, 9, 22, 0, 0, 0, 0));
        send(mk(5, 5, 23, 0, 0));
        idle();
        drain();
        chk("drop_err_code", err_code, 1);
        do_reset();

        // Reserved first, then delim without end_of_job
        send(mk(1, 2, 31, 0, 0, 4'hA));
        send(mk(3, 4, 32, 0, 1));
        send(mk(5, 6, 33, 1, 0));
        idle();
        drain();
        chk("rsvd_err_code", err_code, 2);
        do_reset();

        // Cursor wrap near 2^24
        for (int i = 0; i < 255; i++) send(mk(65535, 255, i, 0, 0));
        send(mk(755, 0, 1, 0, 0));
        send(mk(16, 0, 2, 0, 0));
        send(mk(1, 1, 3, 1, 0));
        idle();
        drain();

        // Reset with two words buffered
        mode = 2;
        send(mk(8, 8, 51, 0, 0));
        send(mk(9, 9, 52, 0, 0));
        idle();
        @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        chk("rst_mid_valid", out_valid, 0);
        @(posedge clk);
        #1;
        mode = 0;
        send(mk(4, 4, 53, 0, 0));
        idle();
        chk("rst_mid_pos", out_pos, 0);
        drain();

        // Random traffic with random backpressure
        mode = 1;
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            send(mk($urandom_range(0, 65535), $urandom_range(0, 255),
                    $urandom_range(0, 24'hffffff), r < 15, r < 8 || r == 50,
                    (r > 95) ? 4'h3 : 0, r != 40));
            if ($urandom_range(0, 3) == 0) begin
                idle();
                @(posedge clk);
                #1;
            end
        end
        idle();
        mode = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/job_seq_unpack.md
# job_seq_unpack

Receive-side counterpart of the match-engine sequence packer: accepts the packed 64-bit sequence word stream and decodes it back into literal/match fields. Reconstructs each sequence's job-relative byte position and per-job sequence index, flags malformed words, and presents results through a registered valid/ready output with full-throughput skid buffering. Sits at the head of the sequence consumer path (entropy-coder front end, scoreboard replay).

## Interface
- POS_WIDTH, 24: width of the job-relative byte cursor; cursor arithmetic is modulo 2^POS_WIDTH.
- CNT_WIDTH, 16: width of the per-job sequence index; saturates at all-ones.
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high; one clock, no other reset.
- in_valid  in  1  sequence word present.
- in_seq  in  64  packed word:
  - [0] valid, [1] delim, [2] end_of_job, [3] has_overlap, [7:4] reserved;
  - [15:8] overlap_len, [31:16] lit_len, [55:32] offset, [63:56] match_len.
- in_ready  out  1  word accepted when in_valid && in_ready.
- out_valid  out  1  decoded sequence present.
- out_ready  in  1  downstream accept.
- out_lit_len  out  16  decoded literal length.
- out_match_len  out  8  decoded match length.
- out_offset  out  24  decoded match offset.
- out_has_overlap  out  1  decoded overlap flag.
- out_overlap_len  out  8  decoded overlap length.
- out_pos  out  POS_WIDTH  job-relative byte position of the first literal of this sequence.
- out_seq_idx  out  CNT_WIDTH  index of this sequence within its job, 0-based.
- out_end_of_job  out  1  last sequence of the job.
- out_delim  out  1  last job of a delimited block.
- err  out  1  sticky error, cleared only by rst.
- err_code  out  2  first error captured: 1 = valid bit clear, 2 = reserved nonzero, 3 = delim without end_of_job.

## Operation
- Decode: pure field slicing of in_seq; no arithmetic on the fields.
- Cursor state per job: cur_pos (POS_WIDTH), cur_idx (CNT_WIDTH), both 0 after reset.
- On every accepted good word:
  - out_pos = cur_pos, out_seq_idx = cur_idx;
  - then cur_pos += lit_len + match_len (zero-extended, modulo wrap);
  - cur_idx += 1, saturating at all-ones.
- Accepted good word with end_of_job=1: cur_pos and cur_idx return to 0 for the next word.
- Error checks on each accepted word, priority code 1 > 2 > 3:
  - Code 1 (bit0 = 0): word dropped, never forwarded; cursor unchanged.
  - Code 2 (bits[7:4] nonzero): word forwarded normally.
  - Code 3 (delim=1, end_of_job=0): word forwarded normally; forwarded out_delim is forced to 0.
- err sets on the first error; err_code latches only on the 0→1 transition of err.
- Consumer state machine, states EMPTY / ONE / TWO (occupancy of output register plus skid register):
  - EMPTY, accept → ONE.
  - ONE, accept without drain → TWO.
  - ONE, drain without accept → EMPTY.
  - ONE, accept and drain → ONE.
  - TWO, drain → ONE; in_ready is 0 while in TWO.
- Ordering strictly preserved; no word is duplicated or lost except dropped code-1 words.

## Timing
- Reset values:
  - out_valid = 0, in_ready = 1, err = 0, err_code = 0;
  - all out_* data fields = 0;
  - cursor = 0, state EMPTY.
- in_ready is a register: 1 in EMPTY/ONE, 0 in TWO. It does not combinationally depend on out_ready.
- Latency: word accepted in cycle N appears on out_* in cycle N+1 when the output register is free.
- Throughput: one word per cycle while out_ready is held high.
- out_* must remain stable while out_valid && !out_ready.
- Dropped (code-1) word: consumes its input cycle, produces no output, changes no state except err/err_code.
- end_of_job word accepted in cycle N: the next accepted word (cycle N+1 or later) sees cur_pos=0, cur_idx=0.
- rst asserted mid-stream: all buffered words are discarded, cursor cleared, err cleared, state EMPTY on the following cycle.

## Structure
- Shared package/header constants: field bit positions and widths of the 64-bit word (SEQ_VALID_BIT … SEQ_MATCH_LEN_LSB), err_code encodings. The packer must use the same constants.
- One natural sub-module: seq_skid_buf, a 2-entry valid/ready skid buffer parameterised on payload width. The cursor and error logic live in the top.

## Test plan
- Single job, three words (lit 5/match 4, lit 0/match 10, lit 3/match 0 end_of_job) with out_ready=1 → out_pos 0, 9, 19; out_seq_idx 0, 1, 2; each output one cycle after acceptance.
- Two jobs back-to-back, second word has delim=1, end_of_job=1 → second job starts at out_pos 0, out_seq_idx 0; out_delim=1 on the job's last word.
- out_ready=0 for 4 cycles under continuous input → in_ready drops after 2 accepts; out_* held stable; release yields all words in order, none lost.
- Word with bit0=0 between two good words → only the 2 good words emerge; err=1, err_code=1; cursor continuous across the gap.
- Reserved=4'hA, then later delim without end_of_job → err_code stays 2; the delim word is forwarded with out_delim=0.
- cur_pos near 2^24-1 plus lit 16 / match 0 → wraps modulo; rst mid-stream with 2 words buffered → out_valid=0 next cycle, next word out_pos=0.
